context_hazard_ctrl: RTL and testbench

Parametrised context-memory read/write controller for the JPEG-LS regular-mode pipeline. Tracks every context index Q in flight between issue (start_enc) and update return (start_enc_feedback) over a configurable feedback latency. Decides per pixel whether the context must be read from memory or forwarded from an in-flight stage, and gates or coalesces write-backs. Sits between context computation and the context memory / context-update stage.

---
 rtl/context_hazard_ctrl_pkg.sv | 17 +
 rtl/context_hazard_ctrl_stage.sv | 25 ++
 rtl/context_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_context_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/context_hazard_ctrl_pkg.sv
// Shared widths and defaults for the JPEG-LS context hazard controller.
// STG_W is derived from the deepest legal feedback latency.
package context_hazard_ctrl_pkg;

    localparam int Q_LENGTH_DEF   = 9;
    localparam int CONTEXT_RW_DEF = 1;
    localparam int PIPE_DEPTH_DEF = 2;
    localparam int PIPE_DEPTH_MAX = 4;
    localparam int CNT_W_DEF      = 16;

    function automatic int stg_w_of(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int STG_W_DEF = stg_w_of(PIPE_DEPTH_MAX);

endpackage

// File: rtl/context_hazard_ctrl_stage.sv
// One {valid, tag} slot of the in-flight context tag pipeline.
module ctx_tag_stage
    import context_hazard_ctrl_pkg::*;
#(
    parameter int Q_length = Q_LENGTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [Q_length-1:0] d_tag,
    output logic                valid,
    output logic [Q_length-1:0] tag
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
        end else begin
            valid <= d_valid;
            tag   <= d_tag;
        end
    end

endmodule

// File: rtl/context_hazard_ctrl.sv
// Context-memory read/forward/write-back controller: tracks in-flight context
// indices between issue and update return and resolves read-after-update hazards.
module context_hazard_ctrl
    import context_hazard_ctrl_pkg::*;
#(
    parameter int Q_length   = Q_LENGTH_DEF,
    parameter int Context_rw = CONTEXT_RW_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int COALESCE   = 1,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STG_W      = STG_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_enc,
    input  logic [Q_length-1:0]   Q,
    input  logic                  start_enc_feedback,
    input  logic [Q_length-1:0]   Q_Feedback,
    input  logic [Context_rw-1:0] determineWrite,
    output logic                  read_Context_Memory,
    output logic                  fwd_valid,
    output logic [STG_W-1:0]      fwd_stage,
    output logic [Context_rw-1:0] write_Context_Memory,
    output logic                  seq_err,
    output logic [CNT_W-1:0]      read_count,
    output logic [CNT_W-1:0]      fwd_count
);

    localparam int TAIL = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0]               stg_valid;
    logic [PIPE_DEPTH-1:0][Q_length-1:0] stg_tag;
    logic [PIPE_DEPTH-1:0]               d_valid;
    logic [PIPE_DEPTH-1:0][Q_length-1:0] d_tag;

    // Stage 0 captures the current issue; every later stage takes its predecessor.
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign d_valid[i] = start_enc;
            assign d_tag[i]   = Q;
        end else begin : g_body
            assign d_valid[i] = stg_valid[i-1];
            assign d_tag[i]   = stg_tag[i-1];
        end

        ctx_tag_stage #(.Q_length(Q_length)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .d_valid (d_valid[i]),
            .d_tag   (d_tag[i]),
            .valid   (stg_valid[i]),
            .tag     (stg_tag[i])
        );
    end

    logic [PIPE_DEPTH-1:0] hit;
    logic [STG_W-1:0]      hit_stage;
    logic                  coalesce_hit;
    logic                  tail_valid;
    logic [Q_length-1:0]   tail_tag;

    assign tail_valid = stg_valid[TAIL];
    assign tail_tag   = stg_tag[TAIL];

    // Descending scan so the youngest matching stage wins.
    always_comb begin
        hit       = '0;
        hit_stage = '0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            hit[i] = stg_valid[i] && (stg_tag[i] == Q);
            if (hit[i])
                hit_stage = STG_W'(i);
        end
    end

    // A younger in-flight copy of the tail's context will write it again later.
    always_comb begin
        coalesce_hit = 1'b0;
        for (int j = 0; j < TAIL; j++)
            if (stg_valid[j] && (stg_tag[j] == tail_tag))
                coalesce_hit = 1'b1;
    end

    always_comb begin
        read_Context_Memory = 1'b0;
        fwd_valid           = 1'b0;
        fwd_stage           = '0;
        if (start_enc) begin
            if (|hit) begin
                fwd_valid = 1'b1;
                fwd_stage = hit_stage;
            end else begin
                read_Context_Memory = 1'b1;
            end
        end
    end

    always_comb begin
        write_Context_Memory = '0;
        if (start_enc_feedback && tail_valid && !((COALESCE != 0) && coalesce_hit))
            write_Context_Memory = determineWrite;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_err    <= 1'b0;
            read_count <= '0;
            fwd_count  <= '0;
        end else begin
            if (start_enc_feedback && (!tail_valid || (Q_Feedback != tail_tag)))
                seq_err <= 1'b1;
            if (read_Context_Memory && (read_count != {CNT_W{1'b1}}))
                read_count <= read_count + CNT_W'(1);
            if (fwd_valid && (fwd_count != {CNT_W{1'b1}}))
                fwd_count <= fwd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_context_hazard_ctrl.sv
// Directed checks of context_hazard_ctrl; u1 disables coalescing and uses
// 2-bit counters so saturation is reachable.
module tb_context_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_enc;
    logic [8:0] Q;
    logic       start_enc_feedback;
    logic [8:0] Q_Feedback;
    logic [0:0] determineWrite;

    logic        rd0, fv0, se0, rd1, fv1, se1;
    logic [1:0]  fs0, fs1;
    logic [0:0]  wr0, wr1;
    logic [15:0] rc0, fc0;
    logic [1:0]  rc1, fc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    context_hazard_ctrl #(.PIPE_DEPTH(2), .COALESCE(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .start_enc(start_enc), .Q(Q),
        .start_enc_feedback(start_enc_feedback), .Q_Feedback(Q_Feedback),
        .determineWrite(determineWrite), .read_Context_Memory(rd0),
        .fwd_valid(fv0), .fwd_stage(fs0), .write_Context_Memory(wr0),
        .seq_err(se0), .read_count(rc0), .fwd_count(fc0)
    );

    context_hazard_ctrl #(.PIPE_DEPTH(2), .COALESCE(0), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .start_enc(start_enc), .Q(Q),
        .start_enc_feedback(start_enc_feedback), .Q_Feedback(Q_Feedback),
        .determineWrite(determineWrite), .read_Context_Memory(rd1),
        .fwd_valid(fv1), .fwd_stage(fs1), .write_Context_Memory(wr1),
        .seq_err(se1), .read_count(rc1), .fwd_count(fc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic se, input logic [8:0] q, input logic fb,
                         input logic [8:0] qf, input logic dw);
        start_enc          = se;
        Q                  = q;
        start_enc_feedback = fb;
        Q_Feedback         = qf;
        determineWrite     = dw;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        // state straight out of reset
        chk("rst_read", rd0, 0);
        chk("rst_fwd", fv0, 0);
        chk("rst_write", wr0, 0);
        chk("rst_seq_err", se0, 0);
        chk("rst_rcnt", rc0, 0);
        chk("rst_fcnt", fc0, 0);

        // Q=1 held four cycles, matching feedback from the tail cycle on
        drive(1, 1, 0, 0, 0);
        chk("t1_c0_read", rd0, 1);
        chk("t1_c0_fwd", fv0, 0);
        step();
        drive(1, 1, 0, 0, 0);
        chk("t1_c1_fwd", fv0, 1);
        chk("t1_c1_stage", fs0, 0);
        chk("t1_c1_read", rd0, 0);
        step();
        drive(1, 1, 1, 1, 0);
        chk("t1_c2_fwd", fv0, 1);
        chk("t1_c2_stage", fs0, 0);
        chk("t1_c2_write", wr0, 0);
        step();
        drive(1, 1, 1, 1, 0);
        step();
        drive(0, 0, 1, 1, 0);
        chk("t1_idle_read", rd0, 0);
        chk("t1_idle_fwd", fv0, 0);
        step();
        drive(0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t1_seq_err", se0, 0);
        chk("t1_rcnt", rc0, 1);
        chk("t1_fcnt", fc0, 3);
        chk("t1_fcnt_u1", fc1, 3);

        // 5, 7, 5 -> third forwards from stage 1
        do_reset();
        drive(1, 5, 0, 0, 0);
        chk("t2_5_read", rd0, 1);
        step();
        drive(1, 7, 0, 0, 0);
        chk("t2_7_read", rd0, 1);
        step();
        drive(1, 5, 0, 0, 0);
        chk("t2_5b_fwd", fv0, 1);
        chk("t2_5b_stage", fs0, 1);
        chk("t2_5b_read", rd0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t2_rcnt", rc0, 2);
        chk("t2_fcnt", fc0, 1);

        // single write-back two cycles after issue
        do_reset();
        drive(1, 10, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 10, 1);
        chk("t3_write", wr0, 1);
        chk("t3_write_u1", wr1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t3_seq_err", se0, 0);

        // back-to-back 10s: older write coalesced only when enabled
        do_reset();
        drive(1, 10, 0, 0, 0);
        step();
        drive(1, 10, 0, 0, 0);
        step();
        drive(0, 0, 1, 10, 1);
        chk("t4_first_coal", wr0, 0);
        chk("t4_first_nocoal", wr1, 1);
        step();
        drive(0, 0, 1, 10, 1);
        chk("t4_second_coal", wr0, 1);
        chk("t4_second_nocoal", wr1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t4_seq_err", se0, 0);

        // wrong feedback tag -> sticky seq_err until reset
        do_reset();
        drive(1, 3, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 4, 1);
        chk("t5_write", wr0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t5_seq_err_set", se0, 1);
        repeat (3) step();
        chk("t5_seq_err_sticky", se0, 1);
        do_reset();
        chk("t5_seq_err_clr", se0, 0);

        // reset mid-stream drops in-flight items
        drive(1, 9, 0, 0, 0);
        step();
        drive(1, 9, 0, 0, 0);
        step();
        reset = 1'b1;
        drive(1, 9, 0, 0, 0);
        chk("t6_rst_read", rd0, 1);
        chk("t6_rst_fwd", fv0, 0);
        step();
        chk("t6_rst_rcnt", rc0, 0);
        reset = 1'b0;
        // late feedback for a dropped item arrives with an empty tail
        drive(1, 9, 1, 9, 1);
        chk("t6_read", rd0, 1);
        chk("t6_fwd", fv0, 0);
        chk("t6_write_gated", wr0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t6_rcnt", rc0, 1);
        chk("t6_late_fb_err", se0, 1);

        // five distinct reads: u1's 2-bit counter pins at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 9'(20 + k), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("t7_rcnt", rc0, 5);
        chk("t7_rcnt_sat", rc1, 3);
        chk("t7_fcnt", fc0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
